// File: rtl/spi_frame_loader_pkg.sv
// Shared constants for the SPI frame loader: FSM encodings, error counter width
// and the saturating increment used by the error counter.
package spi_frame_loader_pkg;

    localparam int ERR_CNT_W = 4;

    localparam logic [1:0] LDR_IDLE   = 2'b00;
    localparam logic [1:0] LDR_SHIFT  = 2'b01;
    localparam logic [1:0] LDR_COMMIT = 2'b10;
    localparam logic [1:0] LDR_DRAIN  = 2'b11;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spi_frame_loader_if.sv
// Serial link plus cache write port of the frame loader; the master side drives
// chip selects, mosi and the processor run request.
import spi_frame_loader_pkg::*;

interface spi_frame_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                 csi_n_in;
    logic                 csd_n_in;
    logic                 mosi_in;
    logic                 proc_en_in;
    logic                 wr_en_out;
    logic                 wr_sel_out;
    logic [ADDR_W-1:0]    wr_addr_out;
    logic [DATA_W-1:0]    wr_data_out;
    logic                 busy_out;
    logic                 frame_err_out;
    logic [ERR_CNT_W-1:0] err_cnt_out;
    logic                 miso_out;

    modport master (
        output csi_n_in, csd_n_in, mosi_in, proc_en_in,
        input  wr_en_out, wr_sel_out, wr_addr_out, wr_data_out,
        input  busy_out, frame_err_out, err_cnt_out, miso_out
    );

    modport slave (
        input  csi_n_in, csd_n_in, mosi_in, proc_en_in,
        output wr_en_out, wr_sel_out, wr_addr_out, wr_data_out,
        output busy_out, frame_err_out, err_cnt_out, miso_out
    );
endinterface

// File: rtl/spi_frame_loader_frame_shifter.sv
// Serial-in/parallel-out frame register. load restarts a frame with din at the
// LSB; shift appends din at the LSB; par_load captures a whole word.
module frame_shifter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         din,
    input  logic         par_load,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (par_load)
            q <= par_in;
        else if (load)
            q <= {{(W-1){1'b0}}, din};
        else if (shift)
            q <= {q[W-2:0], din};
    end
endmodule

// File: rtl/spi_frame_loader.sv
// Deserialises 12-bit MSB-first frames into single-cycle icache/dcache writes.
// Optional SPI_FRAME_LOADER_ECHO_EN: miso echoes the last committed frame.
module spi_frame_loader
    import spi_frame_loader_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    spi_frame_loader_if.slave bus
);
    localparam int FRAME_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

    logic [1:0]           state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 sel;
    logic [FRAME_W-1:0]   frame;
    logic                 sh_load, sh_shift, err;
    logic                 wr_en_q, wr_sel_q, frame_err_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic csi_lo, csd_lo, both_lo, both_hi, one_lo, own_lo, full;
    assign csi_lo  = !bus.csi_n_in;
    assign csd_lo  = !bus.csd_n_in;
    assign both_lo = csi_lo && csd_lo;
    assign both_hi = !csi_lo && !csd_lo;
    assign one_lo  = csi_lo ^ csd_lo;
    assign own_lo  = sel ? csd_lo : csi_lo;
    assign full    = (cnt == FULL_CNT);

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        case (state)
            LDR_IDLE: begin
                if (!bus.proc_en_in) begin
                    if (both_lo) begin
                        err       = 1'b1;
                        state_nxt = LDR_DRAIN;
                    end else if (one_lo) begin
                        sh_load   = 1'b1;
                        state_nxt = LDR_SHIFT;
                    end
                end
            end
            LDR_SHIFT: begin
                if (both_lo || bus.proc_en_in) begin
                    err       = 1'b1;
                    state_nxt = LDR_DRAIN;
                end else if (both_hi) begin
                    if (full) begin
                        state_nxt = LDR_COMMIT;
                    end else begin
                        err       = 1'b1;
                        state_nxt = LDR_IDLE;
                    end
                end else if (own_lo && !full) begin
                    sh_shift = 1'b1;
                end else begin
                    // overrun, or the chip select swapped mid-frame
                    err       = 1'b1;
                    state_nxt = LDR_DRAIN;
                end
            end
            LDR_COMMIT: state_nxt = LDR_IDLE;
            LDR_DRAIN:  if (both_hi) state_nxt = LDR_IDLE;
            default:    state_nxt = LDR_IDLE;
        endcase
    end

    frame_shifter #(.W(FRAME_W)) u_frame (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .shift    (sh_shift),
        .din      (bus.mosi_in),
        .par_load (1'b0),
        .par_in   ('0),
        .q        (frame)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LDR_IDLE;
            cnt         <= '0;
            sel         <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state       <= state_nxt;
            frame_err_q <= err;
            wr_en_q     <= (state == LDR_COMMIT);
            if (err)
                err_cnt_q <= sat_inc(err_cnt_q);
            if (sh_load) begin
                cnt <= CNT_W'(1);
                sel <= csd_lo;
            end else if (sh_shift) begin
                cnt <= cnt + 1'b1;
            end else if (state_nxt != LDR_SHIFT) begin
                cnt <= '0;
            end
            if (state == LDR_COMMIT) begin
                wr_sel_q  <= sel;
                wr_addr_q <= frame[ADDR_W-1:0];
                wr_data_q <= frame[FRAME_W-1:ADDR_W];
            end
        end
    end

`ifdef SPI_FRAME_LOADER_ECHO_EN
    logic [FRAME_W-1:0] echo;
    logic [CNT_W-1:0]   echo_idx;

    frame_shifter #(.W(FRAME_W)) u_echo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .shift    (1'b0),
        .din      (1'b0),
        .par_load (state == LDR_COMMIT),
        .par_in   (frame),
        .q        (echo)
    );

    // cnt runs 1..FRAME_W across the SHIFT cycles, selecting MSB first
    assign echo_idx     = FULL_CNT - cnt;
    assign bus.miso_out = (state == LDR_SHIFT && cnt != '0) ? echo[echo_idx] : 1'b0;
`else
    assign bus.miso_out = 1'b0;
`endif

    assign bus.busy_out      = (state != LDR_IDLE);
    assign bus.wr_en_out     = wr_en_q;
    assign bus.wr_sel_out    = wr_sel_q;
    assign bus.wr_addr_out   = wr_addr_q;
    assign bus.wr_data_out   = wr_data_q;
    assign bus.frame_err_out = frame_err_q;
    assign bus.err_cnt_out   = err_cnt_q;
endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: expected writes go into a scoreboard queue
// that a negedge monitor drains; error counter, latency and echo checked inline.
module tb_spi_frame_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_frame_loader_if bus ();

    spi_frame_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vecs = 0;
    int miscmp = 0;
    int err_pulses = 0;
    int e0;
    bit busy_seen = 1'b0;
    logic [12:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic echo_bit(input logic [11:0] e, input int k);
`ifdef SPI_FRAME_LOADER_ECHO_EN
        return e[k];
`else
        return e[k] & 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        logic [12:0] e;
        if (rst_n) begin
            if (bus.frame_err_out) err_pulses++;
            if (bus.busy_out) busy_seen = 1'b1;
            if (bus.wr_en_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_cmd", {bus.wr_sel_out, bus.wr_addr_out, bus.wr_data_out}, e);
                end
            end
        end
    end

    task automatic step(input logic ci, input logic cd, input logic m, input logic pe);
        @(posedge clk);
        #2;
        bus.csi_n_in   = ci;
        bus.csd_n_in   = cd;
        bus.mosi_in    = m;
        bus.proc_en_in = pe;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // sel 0 = csi (icache), 1 = csd (dcache); pe_at >= 0 raises proc_en from that bit on
    task automatic shift_bits(input logic sel, input logic [11:0] f, input int n,
                              input int pe_at, input logic chk_echo, input logic [11:0] echo_exp);
        for (int i = 0; i < n; i++) begin
            step(sel, !sel, (i < 12) ? f[11-i] : 1'b0, (pe_at >= 0 && i >= pe_at));
            if (chk_echo && i >= 1 && i < 12) begin
                #1;
                chk("miso_echo", bus.miso_out, echo_bit(echo_exp, 12 - i));
            end
        end
    endtask

    task automatic release_cs(input logic chk_echo, input logic [11:0] echo_exp);
        idle(1);
        if (chk_echo) begin
            #1;
            chk("miso_echo_last", bus.miso_out, echo_bit(echo_exp, 0));
        end
    endtask

    task automatic commit_check();
        @(posedge clk);
        #1;
        chk("commit_state_no_strobe", bus.wr_en_out, 1'b0);
        chk("commit_state_busy", bus.busy_out, 1'b1);
        @(posedge clk);
        #1;
        chk("strobe_latency", bus.wr_en_out, 1'b1);
        chk("busy_low_after_commit", bus.busy_out, 1'b0);
        @(posedge clk);
        #1;
        chk("strobe_one_cycle", bus.wr_en_out, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.csi_n_in = 1'b1; bus.csd_n_in = 1'b1; bus.mosi_in = 1'b0; bus.proc_en_in = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.csi_n_in = 1'b1; bus.csd_n_in = 1'b1; bus.mosi_in = 1'b0; bus.proc_en_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wr_en", bus.wr_en_out, 1'b0);
        chk("rst_busy", bus.busy_out, 1'b0);
        chk("rst_err_cnt", bus.err_cnt_out, 4'd0);
        chk("rst_frame_err", bus.frame_err_out, 1'b0);
        chk("rst_miso", bus.miso_out, 1'b0);
        chk("rst_wr_word", {bus.wr_sel_out, bus.wr_addr_out, bus.wr_data_out}, 13'h0);
        rst_n = 1'b1;
        idle(2);

        // good icache frame A5/3
        exp_q.push_back({1'b0, 4'h3, 8'hA5});
        shift_bits(1'b0, 12'hA53, 12, -1, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        commit_check();
        chk("t1_err_cnt", bus.err_cnt_out, 4'd0);

        // good dcache frame 7F/F
        exp_q.push_back({1'b1, 4'hF, 8'h7F});
        shift_bits(1'b1, 12'h7FF, 12, -1, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        commit_check();

        // short frame then a good one
        e0 = err_pulses;
        shift_bits(1'b1, 12'h123, 11, -1, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        idle(3);
        chk("short_err_cnt", bus.err_cnt_out, 4'd1);
        chk("short_err_pulse", err_pulses - e0, 1);
        exp_q.push_back({1'b0, 4'h7, 8'h5A});
        shift_bits(1'b0, 12'h5A7, 12, -1, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        commit_check();
        chk("after_short_err_cnt", bus.err_cnt_out, 4'd1);

        // overrun, both-low, saturation
        do_reset();
        e0 = err_pulses;
        shift_bits(1'b0, 12'hFFF, 14, -1, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        idle(2);
        chk("overrun_err_cnt", bus.err_cnt_out, 4'd1);
        shift_bits(1'b0, 12'h800, 4, -1, 1'b0, 12'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        release_cs(1'b0, 12'h0);
        idle(2);
        chk("both_low_err_cnt", bus.err_cnt_out, 4'd2);
        repeat (18) begin
            shift_bits(1'b1, 12'h000, 3, -1, 1'b0, 12'h0);
            release_cs(1'b0, 12'h0);
            idle(1);
        end
        idle(2);
        chk("err_cnt_saturates", bus.err_cnt_out, 4'd15);
        chk("err_pulse_total", err_pulses - e0, 20);

        // processor lockout and mid-frame abort
        do_reset();
        busy_seen = 1'b0;
        shift_bits(1'b0, 12'hA53, 12, 0, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        idle(2);
        chk("lockout_no_busy", busy_seen, 1'b0);
        chk("lockout_err_cnt", bus.err_cnt_out, 4'd0);
        e0 = err_pulses;
        shift_bits(1'b0, 12'h3C3, 12, 6, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        idle(2);
        chk("abort_err_cnt", bus.err_cnt_out, 4'd1);
        chk("abort_err_pulse", err_pulses - e0, 1);

        // echo: zeros before any commit, then the committed C35
        exp_q.push_back({1'b0, 4'h5, 8'hC3});
        shift_bits(1'b0, 12'hC35, 12, -1, 1'b1, 12'h000);
        release_cs(1'b1, 12'h000);
        commit_check();
        exp_q.push_back({1'b1, 4'h0, 8'h00});
        shift_bits(1'b1, 12'h000, 12, -1, 1'b1, 12'hC35);
        release_cs(1'b1, 12'hC35);
        commit_check();
        chk("miso_idle", bus.miso_out, 1'b0);

        // async reset mid-frame
        exp_q.push_back({1'b1, 4'h6, 8'h9C});
        shift_bits(1'b1, 12'h9C6, 12, -1, 1'b0, 12'h0);
        release_cs(1'b0, 12'h0);
        commit_check();
        shift_bits(1'b0, 12'hFFF, 5, -1, 1'b0, 12'h0);
        #1;
        chk("pre_reset_busy", bus.busy_out, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy_out, 1'b0);
        chk("async_rst_err_cnt", bus.err_cnt_out, 4'd0);
        chk("async_rst_wr_word", {bus.wr_sel_out, bus.wr_addr_out, bus.wr_data_out}, 13'h0);
        chk("async_rst_wr_en", bus.wr_en_out, 1'b0);
        idle(1);
        rst_n = 1'b1;
        idle(4);
        chk("post_rst_idle", bus.busy_out, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule
